// File: rtl/life_encoder_pkg.sv
// Shared types and defaults for the live-cell encoder.
package life_encoder_pkg;

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_EMIT = 1'b1
  } enc_state_t;

  localparam int ENC_DEFAULT_N = 16;

endpackage : life_encoder_pkg

// File: rtl/live_cell_encoder_lsb_finder.sv
// Combinational lowest-set-bit finder: index of the lowest set bit, plus
// flags for "exactly one bit set" and "any bit set".
module lsb_finder #(
  parameter int N     = 16,
  parameter int IDX_W = $clog2(N)
) (
  input  logic [N-1:0]     vec,
  output logic [IDX_W-1:0] idx,
  output logic             one_hot,
  output logic             any
);

  logic [N-1:0] vec_minus_one_s;

  // Scan from the top down so the lowest set bit is the final one to win.
  always_comb begin
    idx = {IDX_W{1'b0}};
    for (int i = N - 1; i >= 0; i--) begin
      idx = vec[i] ? IDX_W'(i) : idx;
    end
  end

  // Clearing the lowest set bit leaves zero exactly when one bit was set.
  assign vec_minus_one_s = vec - {{(N-1){1'b0}}, 1'b1};
  assign any             = |vec;
  assign one_hot         = any && ((vec & vec_minus_one_s) == {N{1'b0}});

endmodule : lsb_finder

// File: rtl/live_cell_encoder.sv
// Sequential priority encoder: streams the index of each set bit of a loaded
// vector, lowest first. Optional popcount output under LIVE_CELL_ENCODER_POPCOUNT_EN.
module live_cell_encoder
  import life_encoder_pkg::*;
#(
  parameter int N     = ENC_DEFAULT_N,
  parameter int IDX_W = $clog2(N)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             ena,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [N-1:0]     in_vec,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [IDX_W-1:0] out_idx,
  output logic             out_last,
  output logic             done,
  output logic [IDX_W:0]   pop_count
);

  enc_state_t       state_r;
  enc_state_t       state_nxt_s;
  logic [N-1:0]     pending_r;
  logic [N-1:0]     pending_nxt_s;
  logic             done_r;
  logic             done_nxt_s;
  logic [IDX_W-1:0] lsb_idx_s;
  logic             lsb_one_hot_s;
  logic             lsb_any_s;
  logic             accept_s;
  logic             emit_s;

  lsb_finder #(
    .N     (N),
    .IDX_W (IDX_W)
  ) u_lsb_finder (
    .vec     (pending_r),
    .idx     (lsb_idx_s),
    .one_hot (lsb_one_hot_s),
    .any     (lsb_any_s)
  );

  // Outputs are derived from registered state only, never from out_ready.
  assign emit_s    = (state_r == S_EMIT);
  assign in_ready  = ena && (state_r == S_IDLE);
  assign accept_s  = in_valid && in_ready;
  assign out_valid = emit_s && lsb_any_s;
  assign out_idx   = out_valid ? lsb_idx_s : {IDX_W{1'b0}};
  assign out_last  = out_valid && lsb_one_hot_s;
  assign done      = done_r;

  // Next-state, next-pending and done-pulse logic.
  always_comb begin
    state_nxt_s   = state_r;
    pending_nxt_s = pending_r;
    done_nxt_s    = 1'b0;
    case (state_r)
      S_IDLE: begin
        if (accept_s) begin
          pending_nxt_s = in_vec;
          if (|in_vec) begin
            state_nxt_s = S_EMIT;
          end else begin
            done_nxt_s = 1'b1;
          end
        end else begin
          pending_nxt_s = pending_r;
        end
      end
      S_EMIT: begin
        if (out_valid && out_ready) begin
          // x & (x-1) drops exactly the bit just emitted.
          pending_nxt_s = pending_r & (pending_r - {{(N-1){1'b0}}, 1'b1});
          if (lsb_one_hot_s) begin
            state_nxt_s = S_IDLE;
            done_nxt_s  = 1'b1;
          end else begin
            state_nxt_s = S_EMIT;
          end
        end else if (!lsb_any_s) begin
          // Unreachable with consistent state; recover to idle rather than hang.
          state_nxt_s = S_IDLE;
        end else begin
          state_nxt_s = S_EMIT;
        end
      end
      default: begin
        state_nxt_s   = S_IDLE;
        pending_nxt_s = {N{1'b0}};
      end
    endcase
  end

  // State, pending bits and done pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r   <= S_IDLE;
      pending_r <= {N{1'b0}};
      done_r    <= 1'b0;
    end else begin
      state_r   <= state_nxt_s;
      pending_r <= pending_nxt_s;
      done_r    <= done_nxt_s;
    end
  end

`ifdef LIVE_CELL_ENCODER_POPCOUNT_EN
  logic [IDX_W:0] pop_count_r;

  function automatic logic [IDX_W:0] count_ones(input logic [N-1:0] v);
    logic [IDX_W:0] c;
    c = {(IDX_W+1){1'b0}};
    for (int i = 0; i < N; i++) begin
      c = c + {{IDX_W{1'b0}}, v[i]};
    end
    return c;
  endfunction

  // Popcount captured at load and held until the next load.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pop_count_r <= {(IDX_W+1){1'b0}};
    end else if (accept_s) begin
      pop_count_r <= count_ones(in_vec);
    end else begin
      pop_count_r <= pop_count_r;
    end
  end

  assign pop_count = pop_count_r;
`else
  assign pop_count = {(IDX_W+1){1'b0}};
`endif

endmodule : live_cell_encoder
